// File: rtl/seg_disp_arbiter_if.sv
// Two-requester byte handshake into the shared seven-segment decoder arbiter.
interface seg_disp_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing a two-digit hex decoder; each accepted byte is
// held on num1/num0 for HOLD_CYCLES clocks, blank asserted when idle.
module seg_disp_arbiter #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  seg_disp_arbiter_if.slave   req,
  output logic [3:0]          num0,
  output logic [3:0]          num1,
  output logic                blank,
  output logic                owner
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          open;
  logic          grant;
  logic          accept;

  // Window opens in IDLE or on the final hold cycle, so back-to-back bytes
  // see no blank gap.
  assign open = (state == IDLE) || (cnt == '0);

  always_comb begin
    grant = 1'b0;
    if (req.req0_valid && req.req1_valid) grant = ~last;
    else if (req.req1_valid)              grant = 1'b1;
  end

  assign req.req0_ready = open & ~grant & req.req0_valid & ~rst;
  assign req.req1_ready = open &  grant & req.req1_valid & ~rst;
  assign accept         = req.req0_ready | req.req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      num0  <= 4'h0;
      num1  <= 4'h0;
      blank <= 1'b1;
      owner <= 1'b0;
      cnt   <= '0;
      last  <= 1'b1;
    end else if (accept) begin
      {num1, num0} <= req.req1_ready ? req.req1_data : req.req0_data;
      owner        <= req.req1_ready;
      last         <= req.req1_ready;
      blank        <= 1'b0;
      cnt          <= CNT_LOAD;
      state        <= SHOW;
    end else if (state == SHOW) begin
      // cnt is only decremented while nonzero, so it never wraps.
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        state <= IDLE;
        blank <= 1'b1;
      end
    end
  end
endmodule
